// File: rtl/err_diffuse_accum.sv
// err_diffuse_accum: Floyd-Steinberg error accumulation ahead of the 11-to-9 clamp.
// Each accepted grey pixel gets the weighted errors of its already-quantized
// neighbours added (7/16 left, 1/16 up-left, 5/16 up, 3/16 up-right). The sum is
// returned to downstream logic. The quantization error that comes back is kept
// as the left neighbour and is stored in a single-line RAM for the next line.
module err_diffuse_accum #(
    parameter int H_RES = 1600,
    parameter int XW    = 11
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sol,
    input  logic        sof,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_pixel,
    output logic        out_valid,
    output logic [10:0] out_sum,
    input  logic [8:0]  err_in
);

    localparam int AW = (H_RES > 1) ? $clog2(H_RES) : 1;
    // Last pixel position of a line.
    localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
    // Highest x whose look-ahead read (x+2) still lands inside the line.
    localparam logic [XW-1:0] X_RD_MAX = XW'(H_RES - 3);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREFETCH = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            pf_q, pf_d;
    logic [XW-1:0]   x_q, x_d;
    logic            first_line_q, first_line_d;

    logic [8:0]      e_left_q;
    logic [8:0]      eul_q;
    logic [8:0]      eu_q;
    logic [8:0]      rd_data_q;      // doubles as the up-right window tap

    logic            out_valid_q;
    logic [10:0]     out_sum_q;
    logic [AW-1:0]   out_x_q;

    logic            accept;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic            wr_en;

    logic [8:0]      lb_mem [H_RES];

    logic            x_first;
    logic            x_last;
    logic [8:0]      el_raw;
    logic [8:0]      t_el, t_eul, t_eu, t_eur;
    logic signed [12:0] ext_el, ext_eul, ext_eu, ext_eur;
    logic signed [12:0] acc;
    logic signed [12:0] w13;
    logic signed [12:0] sum13;
    logic [10:0]     sum_d;

    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    // The write is suppressed during reset so a pending pixel never lands in the RAM.
    assign wr_en     = out_valid_q && rstn;

    // State register and line bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            pf_q         <= 1'b0;
            x_q          <= '0;
            first_line_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pf_q         <= pf_d;
            x_q          <= x_d;
            first_line_q <= first_line_d;
        end
    end

    // Next-state logic: sol restarts the prefetch from any state.
    always_comb begin
        state_d      = state_q;
        pf_d         = pf_q;
        x_d          = x_q;
        first_line_d = first_line_q;
        if (sol) begin
            state_d      = S_PREFETCH;
            pf_d         = 1'b0;
            x_d          = '0;
            first_line_d = sof;
        end else begin
            case (state_q)
                S_PREFETCH: begin
                    if (pf_q) begin
                        state_d = S_RUN;
                        pf_d    = 1'b0;
                    end else begin
                        pf_d    = 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (x_q == X_LAST) begin
                            state_d = S_IDLE;
                            x_d     = '0;
                        end else begin
                            x_d     = x_q + XW'(1);
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // FSM outputs: handshake and line-buffer read requests.
    always_comb begin
        in_ready = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        case (state_q)
            S_PREFETCH: begin
                rd_en   = 1'b1;
                rd_addr = pf_q ? AW'(1) : '0;
            end
            S_RUN: begin
                in_ready = 1'b1;
                if (accept && (x_q <= X_RD_MAX)) begin
                    rd_en   = 1'b1;
                    rd_addr = AW'(x_q + XW'(2));
                end
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Line buffer read port: one-cycle latency, holds its value across bubbles.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= lb_mem[rd_addr];
        end
    end

    // Line buffer write port: the error of the pixel on out_sum overwrites its column.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lb_mem[out_x_q] <= err_in;
        end
    end

    // Previous-line window: load x=0 at the end of prefetch, shift on each accept.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            eul_q <= '0;
            eu_q  <= '0;
        end else if ((state_q == S_PREFETCH) && pf_q && !sol) begin
            eul_q <= '0;
            eu_q  <= rd_data_q;
        end else if (accept) begin
            eul_q <= eu_q;
            eu_q  <= rd_data_q;
        end
    end

    // Left-error register tracks every error returned from downstream.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            e_left_q <= '0;
        end else if (out_valid_q) begin
            e_left_q <= err_in;
        end
    end

    // Weighted error sum with edge and first-line masking.
    always_comb begin
        x_first = (x_q == '0);
        x_last  = (x_q == X_LAST);
        // Back-to-back: the left neighbour's error is still on err_in this cycle.
        el_raw  = out_valid_q ? err_in : e_left_q;
        t_el    = x_first                  ? 9'd0 : el_raw;
        t_eul   = (x_first || first_line_q) ? 9'd0 : eul_q;
        t_eu    = first_line_q             ? 9'd0 : eu_q;
        t_eur   = (x_last || first_line_q)  ? 9'd0 : rd_data_q;
        ext_el  = {{4{t_el[8]}},  t_el};
        ext_eul = {{4{t_eul[8]}}, t_eul};
        ext_eu  = {{4{t_eu[8]}},  t_eu};
        ext_eur = {{4{t_eur[8]}}, t_eur};
        acc     = ext_el * 13'sd7 + ext_eul + ext_eu * 13'sd5 + ext_eur * 13'sd3;
        // Arithmetic shift floors toward minus infinity.
        w13     = acc >>> 4;
        sum13   = $signed({5'b00000, in_pixel}) + w13;
        sum_d   = 11'(sum13);
    end

    // Output register: one result per accepted pixel, one cycle later.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_x_q     <= '0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                out_sum_q <= sum_d;
                out_x_q   <= AW'(x_q);
            end
        end
    end

endmodule

// File: tb/tb_err_diffuse_accum.sv
// Testbench for err_diffuse_accum with a short line (H_RES=4).
// Expected sums come from a line-level model of the diffusion equation.
module tb_err_diffuse_accum;

    localparam int H  = 4;
    localparam int XW = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sol;
    logic        sof;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pixel;
    logic        out_valid;
    logic [10:0] out_sum;
    logic [8:0]  err_in;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int prev_err [H];
    int line_pix [H];
    int line_err [H];
    int exp_sum  [H];
    int got      [H];
    int acc_cyc  [H];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    err_diffuse_accum #(.H_RES(H), .XW(XW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sol       (sol),
        .sof       (sof),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .err_in    (err_in)
    );

    function automatic int floor16(input int a);
        if (a >= 0) return a / 16;
        return -((-a + 15) / 16);
    endfunction

    // Expected sums for the whole line from neighbour errors.
    task automatic model_line(input bit first);
        for (int x = 0; x < H; x++) begin
            int el, eul, eu, eur;
            el  = (x == 0) ? 0 : line_err[x-1];
            eul = (x == 0 || first) ? 0 : prev_err[x-1];
            eu  = first ? 0 : prev_err[x];
            eur = (x == H-1 || first) ? 0 : prev_err[x+1];
            exp_sum[x] = line_pix[x] + floor16(7*el + eul + 5*eu + 3*eur);
        end
    endtask

    // mode 0: continuous valid, 1: 1-0-0-1 pattern, 2: random bubbles
    task automatic run_line(input bit sof_f, input int mode, input string tag);
        int ai, oi, t, budget;
        bit v;
        model_line(sof_f);
        @(negedge clk);
        sol = 1'b1; sof = sof_f; in_valid = 1'b0; err_in = 9'($urandom);
        @(negedge clk);
        sol = 1'b0; sof = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL %s prefetch0_ready got=%0b want=0", tag, in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL %s prefetch1_ready got=%0b want=0", tag, in_ready);
        end
        ai = 0; oi = 0; t = 0; budget = 0;
        while (oi < H && budget < 200) begin
            if (out_valid === 1'b1) begin
                got[oi] = int'($signed(out_sum));
                checks++;
                if (got[oi] !== exp_sum[oi]) begin
                    errors++;
                    $display("FAIL %s sum x=%0d got=%0d want=%0d", tag, oi, got[oi], exp_sum[oi]);
                end
                checks++;
                if (cyc != acc_cyc[oi]) begin
                    errors++;
                    $display("FAIL %s latency x=%0d got_cycle=%0d want_cycle=%0d", tag, oi, cyc, acc_cyc[oi]);
                end
                err_in = 9'(line_err[oi]);
                oi++;
            end else begin
                err_in = 9'($urandom);
            end
            if (ai < H) begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (t % 3 == 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                in_valid = v;
                in_pixel = v ? 8'(line_pix[ai]) : 8'($urandom);
                if (v && in_ready === 1'b1) begin
                    acc_cyc[ai] = cyc + 1;
                    ai++;
                end
                if (in_ready === 1'b1) t++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        if (oi < H) begin
            errors++;
            $display("FAIL %s timeout outputs got=%0d want=%0d", tag, oi, H);
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s end_idle got ready=%0b valid=%0b want 0/0", tag, in_ready, out_valid);
        end
        $display("line %s sof=%0b mode=%0d sums=%0d,%0d,%0d,%0d", tag, sof_f, mode,
                 got[0], got[1], got[2], got[3]);
        for (int x = 0; x < H; x++) prev_err[x] = line_err[x];
    endtask

    task automatic fill_random();
        for (int x = 0; x < H; x++) begin
            line_pix[x] = int'($urandom_range(0, 255));
            line_err[x] = int'($urandom_range(0, 511)) - 256;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; sol = 1'b0; sof = 1'b0; in_valid = 1'b0; in_pixel = '0; err_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 11'd0) begin
            errors++;
            $display("FAIL reset got ready=%0b valid=%0b sum=%0d want 0/0/0", in_ready, out_valid, out_sum);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_idle got ready=%0b want=0", in_ready);
        end
        $display("reset done");
    endtask

    task automatic test_basic();
        for (int x = 0; x < H; x++) begin line_pix[x] = 128; line_err[x] = 0; end
        run_line(1'b1, 0, "basic");
        for (int x = 0; x < H; x++) begin
            checks++;
            if (got[x] !== 128) begin
                errors++; $display("FAIL basic_const x=%0d got=%0d want=128", x, got[x]);
            end
        end
    endtask

    task automatic test_left_error();
        for (int x = 0; x < H; x++) begin line_pix[x] = 100; line_err[x] = 0; end
        line_err[0] = 32;
        run_line(1'b1, 0, "left");
        checks++;
        if (got[1] !== 114) begin
            errors++; $display("FAIL left_const got=%0d want=114", got[1]);
        end
    endtask

    task automatic test_prev_line();
        fill_random();
        for (int x = 0; x < H; x++) line_err[x] = -256;
        run_line(1'b1, 0, "prevA");
        for (int x = 0; x < H; x++) begin line_pix[x] = 0; line_err[x] = 0; end
        run_line(1'b0, 0, "prevB");
        checks++;
        if (got[0] !== -128) begin errors++; $display("FAIL prev_x0 got=%0d want=-128", got[0]); end
        checks++;
        if (got[1] !== -144) begin errors++; $display("FAIL prev_x1 got=%0d want=-144", got[1]); end
        checks++;
        if (got[H-1] !== -96) begin errors++; $display("FAIL prev_xlast got=%0d want=-96", got[H-1]); end
    endtask

    task automatic test_rounding();
        for (int x = 0; x < H; x++) begin line_pix[x] = 50; line_err[x] = 0; end
        line_err[0] = -1;
        run_line(1'b1, 0, "roundA");
        for (int x = 0; x < H; x++) begin line_pix[x] = 0; line_err[x] = 0; end
        run_line(1'b0, 0, "roundB");
        checks++;
        if (got[1] !== -1) begin errors++; $display("FAIL round_floor got=%0d want=-1", got[1]); end
    endtask

    task automatic test_gaps();
        fill_random();
        run_line(1'b0, 1, "gap");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            fill_random();
            run_line(1'b0, 0, "b2b");
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            fill_random();
            run_line(n == 3, 2, "rand");
        end
    endtask

    task automatic test_abort_reset();
        int budget;
        @(negedge clk);
        sol = 1'b1; sof = 1'b1;
        @(negedge clk);
        sol = 1'b0; sof = 1'b0;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 20) begin @(negedge clk); budget++; end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_run got ready=%0b want=1", in_ready); end
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_pixel = 8'($urandom); err_in = '0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_last_out got=%0b want=1", out_valid); end
        sol = 1'b1; sof = 1'b0;
        @(negedge clk);
        sol = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_prefetch got ready=%0b want=0", in_ready); end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_reset got ready=%0b valid=%0b want 0/0", in_ready, out_valid);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_idle got ready=%0b want=0", in_ready); end
        $display("abort+reset done");
        fill_random();
        run_line(1'b1, 0, "postA");
        fill_random();
        run_line(1'b0, 2, "postB");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_left_error();
        test_prev_line();
        test_rounding();
        test_gaps();
        test_back_to_back();
        test_random();
        test_abort_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
